// File: rtl/fifo_write_arbiter_if.sv
// Requester streams and FIFO write-port signals shared by the round-robin
// write arbiter and whatever drives its requesters.
interface fifo_write_arbiter_if #(
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = 4
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         full;
  logic                         w_en;
  logic [DATA_SIZE-1:0]         w_data;
  logic [NUM_REQ-1:0]           grant;

  // Arbiter side: consumes requester streams and the full flag.
  modport slave (
    input  req_valid,
    input  req_data,
    input  full,
    output req_ready,
    output w_en,
    output w_data,
    output grant
  );

  // Requester/FIFO side.
  modport master (
    output req_valid,
    output req_data,
    output full,
    input  req_ready,
    input  w_en,
    input  w_data,
    input  grant
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ valid/ready
// requesters, granting bursts of up to MAX_BURST words on w_clk.
module fifo_write_arbiter #(
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 w_clk,
  input  logic                 w_rst_n,
  fifo_write_arbiter_if.slave  bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  LAST_REQ  = ID_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state;
  logic [NUM_REQ-1:0]   grant_q;
  logic [ID_W-1:0]      last_id;
  logic [CNT_W-1:0]     burst_cnt;

  logic [ID_W-1:0]      owner_id;
  logic [DATA_SIZE-1:0] owner_data;
  logic                 owner_valid;
  logic                 xfer;
  logic                 release_now;
  logic [ID_W-1:0]      search_base;
  logic [ID_W:0]        pick;
  logic                 win_found;
  logic [ID_W-1:0]      win_id;

  // Search order is base+1, base+2, ... wrapping; base itself is tried last,
  // so the previous owner only re-wins when nobody else is valid.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    base);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] sel;
    int              idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(base) + k) % NUM_REQ;
      sel = ID_W'(idx);
      if (valid[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  always_comb begin
    owner_id   = '0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_id   = ID_W'(i);
        owner_data = bus.req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign owner_valid = |(grant_q & bus.req_valid);
  assign xfer        = owner_valid & ~bus.full;
  assign release_now = ~owner_valid | (xfer & (burst_cnt == LAST_BEAT));

  // While granted, re-arbitration on release starts after the current owner,
  // which is what last_id becomes at that same edge.
  assign search_base = (state == GRANT) ? owner_id : last_id;
  assign pick        = rr_pick(bus.req_valid, search_base);
  assign win_found   = pick[ID_W];
  assign win_id      = pick[ID_W-1:0];

  assign bus.grant     = grant_q;
  assign bus.req_ready = grant_q & {NUM_REQ{~bus.full}};
  assign bus.w_en      = xfer;
  assign bus.w_data    = owner_data;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state     <= IDLE;
      grant_q   <= '0;
      last_id   <= LAST_REQ;
      burst_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_found) begin
            state     <= GRANT;
            grant_q   <= NUM_REQ'(1) << win_id;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            last_id   <= owner_id;
            burst_cnt <= '0;
            if (win_found) begin
              grant_q <= NUM_REQ'(1) << win_id;
            end else begin
              grant_q <= '0;
              state   <= IDLE;
            end
          end else if (xfer) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: queue-driven requesters, a grant/burst
// model compared every cycle, and literal expectations for each scenario.
module tb_fifo_write_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.DATA_SIZE(DW), .NUM_REQ(NR)) bus ();

  fifo_write_arbiter #(.DATA_SIZE(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .w_clk  (clk),
    .w_rst_n(rst_n),
    .bus    (bus)
  );

  logic [DW-1:0] q[NR][$];
  logic [DW-1:0] wlog[$];
  logic [NR-1:0] en = '0;
  logic          full_r = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  // Model: current owner (-1 when idle), last owner, words used in this burst.
  int owner = -1;
  int last = NR - 1;
  int cnt = 0;

  logic [NR-1:0] g_s;
  logic          wen_s;
  logic [NR-1:0] rdy_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int from, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(from + k) % NR]) return (from + k) % NR;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = en[i] && (q[i].size() > 0);
      bus.req_data[i*DW +: DW] = bus.req_valid[i] ? q[i][0] : '0;
    end
    bus.full = full_r;
  endtask

  task automatic step();
    logic [NR-1:0] v;
    logic [NR-1:0] acc;
    logic [NR-1:0] exp_g;
    logic          exp_wen;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    if (!rst_n) begin
      owner = -1; last = NR - 1; cnt = 0;
    end
    v = bus.req_valid;
    exp_g   = (owner < 0) ? '0 : NR'(1 << owner);
    exp_wen = (owner >= 0) && v[owner] && !full_r;
    exp_d   = (owner >= 0 && v[owner]) ? q[owner][0] : '0;
    chk("grant", 32'(bus.grant), 32'(exp_g));
    chk("w_en", 32'(bus.w_en), 32'(exp_wen));
    chk("w_data", 32'(bus.w_data), 32'(exp_d));
    chk("req_ready", 32'(bus.req_ready), 32'(full_r ? '0 : exp_g));
    if (bus.grant != '0) chk("grant_onehot", 32'($countones(bus.grant)), 32'd1);
    g_s = bus.grant; wen_s = bus.w_en; rdy_s = bus.req_ready;
    if (bus.w_en) wlog.push_back(bus.w_data);
    acc = bus.req_valid & bus.req_ready;
    if (rst_n) begin
      if (owner < 0) begin
        owner = pick(last, v); cnt = 0;
      end else begin
        if (v[owner] && !full_r) cnt++;
        if (!v[owner] || cnt == MB) begin
          last = owner; owner = pick(last, v); cnt = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (acc[i]) void'(q[i].pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) q[i].delete();
    wlog.delete();
    en = '0; full_r = 1'b0;
    drive();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive();
    // Reset state.
    do_reset();
    chk("reset_grant", 32'(g_s), 32'd0);
    chk("reset_ready", 32'(rdy_s), 32'd0);

    // Single source: A1, B2, C3 from req0.
    q[0] = '{8'hA1, 8'hB2, 8'hC3}; en = '1; drive();
    step(); chk("t1_idle", 32'(g_s), 32'd0);
    step(); chk("t1_grant", 32'(g_s), 32'h1); chk("t1_wen0", 32'(wen_s), 32'd1);
    step(); chk("t1_wen1", 32'(wen_s), 32'd1);
    step(); chk("t1_wen2", 32'(wen_s), 32'd1);
    step(); chk("t1_tail_wen", 32'(wen_s), 32'd0);
    step(); chk("t1_released", 32'(g_s), 32'd0);
    chk("t1_count", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("t1_w0", 32'(wlog[0]), 32'hA1);
      chk("t1_w1", 32'(wlog[1]), 32'hB2);
      chk("t1_w2", 32'(wlog[2]), 32'hC3);
    end

    // Four-way contention, bursts of 4, no bubbles.
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 8; k++) q[i].push_back(8'(i * 16 + k));
    en = '1; drive();
    step();
    for (int c = 0; c < 16; c++) begin
      step();
      chk("t2_wen", 32'(wen_s), 32'd1);
      if (c % 4 == 0) chk("t2_grant", 32'(g_s), 32'(1 << (c / 4)));
    end
    step(); chk("t2_wrap", 32'(g_s), 32'h1);
    for (int c = 0; c < 16; c++)
      if (c < wlog.size()) chk("t2_word", 32'(wlog[c]), 32'((c / 4) * 16 + c % 4));

    // Backpressure during req1's burst.
    do_reset();
    q[1] = '{8'h11, 8'h12, 8'h13, 8'h14}; q[2] = '{8'h21, 8'h22};
    en = '1; drive();
    step(); step(); step();
    full_r = 1'b1; drive();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t3_full_wen", 32'(wen_s), 32'd0);
      chk("t3_full_ready", 32'(rdy_s), 32'd0);
      chk("t3_full_grant", 32'(g_s), 32'h2);
    end
    full_r = 1'b0; drive();
    step(); chk("t3_resume", 32'(wen_s), 32'd1);
    step(); chk("t3_last", 32'(g_s), 32'h2);
    step(); chk("t3_next", 32'(g_s), 32'h4);
    chk("t3_count", 32'(wlog.size()), 32'd5);
    if (wlog.size() == 5) begin
      chk("t3_w2", 32'(wlog[2]), 32'h13);
      chk("t3_w3", 32'(wlog[3]), 32'h14);
      chk("t3_w4", 32'(wlog[4]), 32'h21);
    end

    // Early drop by req2 while req3 waits; req3 then gets a full burst.
    do_reset();
    q[0] = '{8'h01}; q[2] = '{8'h31}; q[3] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    en = 4'b1100; drive();
    step();
    step(); chk("t4_g2", 32'(g_s), 32'h4); chk("t4_w2", 32'(wen_s), 32'd1);
    step(); chk("t4_drop", 32'(g_s), 32'h4); chk("t4_drop_wen", 32'(wen_s), 32'd0);
    en[0] = 1'b1; drive();
    step(); chk("t4_g3", 32'(g_s), 32'h8); chk("t4_w3", 32'(wen_s), 32'd1);
    step(); step();
    step(); chk("t4_beat4", 32'(g_s), 32'h8);
    step(); chk("t4_g0", 32'(g_s), 32'h1);
    chk("t4_count", 32'(wlog.size()), 32'd6);
    if (wlog.size() == 6) begin
      chk("t4_first", 32'(wlog[0]), 32'h31);
      chk("t4_b4", 32'(wlog[4]), 32'h44);
      chk("t4_r0", 32'(wlog[5]), 32'h01);
    end

    // Sole requester across burst boundaries.
    do_reset();
    for (int k = 0; k < 10; k++) q[3].push_back(8'(8'h50 + k));
    en = '1; drive();
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t5_wen", 32'(wen_s), 32'd1);
      chk("t5_grant", 32'(g_s), 32'h8);
    end
    chk("t5_count", 32'(wlog.size()), 32'd10);

    // Asynchronous reset in the middle of req1's burst.
    do_reset();
    q[1] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    en = '1; drive();
    step();
    step(); chk("t6_grant", 32'(g_s), 32'h2);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_grant", 32'(bus.grant), 32'd0);
    chk("t6_async_wen", 32'(bus.w_en), 32'd0);
    chk("t6_async_ready", 32'(bus.req_ready), 32'd0);
    q[0] = '{8'h71, 8'h72}; q[2] = '{8'h81}; q[3] = '{8'h91};
    drive();
    step();
    rst_n = 1'b1;
    step();
    step(); chk("t6_first", 32'(g_s), 32'h1);
    chk("t6_count", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("t6_pre", 32'(wlog[1]), 32'h62);
      chk("t6_post", 32'(wlog[2]), 32'h71);
    end
    chk("t6_q1_left", 32'(q[1].size()), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
